// File: rtl/mem_pkg.sv
// Shared types and constants for the main memory responder: FSM states, word geometry, LFSR seed/taps.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_W     = 8 * WORD_BYTES;
  localparam int unsigned CNT_W      = 5;

  // Reserved: the storage array is never initialised by reset.
  localparam logic [7:0] INIT_BYTE = 8'h00;

  // x^8 + x^6 + x^5 + x^4 + 1, shifted left with feedback into bit 0
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/main_memory_responder_if.sv
// Cache <-> memory port bundle; master is the cache, slave is the memory responder.
interface main_memory_responder_if
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);

  logic                MRead_request;
  logic                MWrite_request;
  logic [ADDR_W-1:0]   MAddress;
  logic [7:0]          MWrite_data;
  logic [WORD_W-1:0]   MRead_data;
  logic                MRead_ready;
  logic                MWrite_done;
  logic                mem_busy;

  modport master (
    output MRead_request, MWrite_request, MAddress, MWrite_data,
    input  MRead_data, MRead_ready, MWrite_done, mem_busy
  );

  modport slave (
    input  MRead_request, MWrite_request, MAddress, MWrite_data,
    output MRead_data, MRead_ready, MWrite_done, mem_busy
  );

endinterface

// File: rtl/mem_byte_array.sv
// Byte storage with one synchronous byte write port and one aligned 4-byte read port.
// Contents are never reset so the array can map onto a RAM macro.
module mem_byte_array
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-3:0] raddr,
  output logic [WORD_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Byte k of the word sits in bits [8k+7:8k]
  for (genvar k = 0; k < WORD_BYTES; k++) begin : g_rd
    assign rdata_c[8*k +: 8] = mem[{raddr, 2'(k)}];
  end

endmodule

// File: rtl/main_memory_responder.sv
// Memory-side responder: serves aligned word reads and byte writes after a programmable latency.
// Optional feature macro: MEM_RANDOM_LATENCY_EN adds 0..3 LFSR-driven extra wait cycles per access.
module main_memory_responder
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic clk,
  input  logic rst,
  main_memory_responder_if.slave bus
);

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [WORD_W-1:0]   rdata_q, rdata_n;
  logic                ready_q, ready_n;
  logic                done_q, done_n;
  logic                busy_q;
  logic                we_c;
  logic                accept_c;
  logic [1:0]          extra_c;
  logic [CNT_W-1:0]    load_c;
  logic [WORD_W-1:0]   word_c;

`ifdef MEM_RANDOM_LATENCY_EN
  logic [7:0] lfsr_q;

  // Steps once per accepted request; low two bits give the extra wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           lfsr_q <= LFSR_SEED;
    else if (accept_c) lfsr_q <= lfsr_next(lfsr_q);
  end

  assign extra_c = lfsr_q[1:0];
`else
  assign extra_c = 2'd0;
`endif

  assign load_c = CNT_W'(LATENCY - 1) + CNT_W'(extra_c);

  mem_byte_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .we      (we_c),
    .waddr   (addr_q),
    .wdata   (bus.MWrite_data),
    .raddr   (addr_q[ADDR_W-1:2]),
    .rdata_c (word_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      addr_q  <= addr_n;
      rdata_q <= rdata_n;
      ready_q <= ready_n;
      done_q  <= done_n;
      busy_q  <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    addr_n   = addr_q;
    rdata_n  = rdata_q;
    ready_n  = 1'b0;
    done_n   = 1'b0;
    we_c     = 1'b0;
    accept_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Read has priority when both requests are raised together
        if (bus.MRead_request) begin
          state_n  = RD_WAIT;
          addr_n   = {bus.MAddress[ADDR_W-1:2], 2'b00};
          cnt_n    = load_c;
          accept_c = 1'b1;
        end else if (bus.MWrite_request) begin
          state_n  = WR_WAIT;
          addr_n   = bus.MAddress;
          cnt_n    = load_c;
          accept_c = 1'b1;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_n = word_c;
          ready_n = 1'b1;
          state_n = HOLD;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      WR_WAIT: begin
        // Write data is taken on the same edge that raises done
        if (cnt_q == '0) begin
          we_c    = 1'b1;
          done_n  = 1'b1;
          state_n = HOLD;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (!bus.MRead_request && !bus.MWrite_request) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.MRead_data  = rdata_q;
  assign bus.MRead_ready = ready_q;
  assign bus.MWrite_done = done_q;
  assign bus.mem_busy    = busy_q;

endmodule
